spi_sram_slave: RTL and testbench
=================================

Name: spi_sram_slave

Overview:
- Synthesizable SPI SRAM responder: the device end of the spi_sram_master link (cs_n/mosi/miso), modelled on the 23LC1024-style command set.
- Used as the on-chip or bench memory behind a spi_cpu_6502 top, so the CPU + cache + SPI master stack runs end to end without an external part.
- Contains the backing byte array, the 8-bit mode register and a backdoor preload port for firmware images.

Parameters:
- MEM_ADDR_BITS, 16: log2 of array size in bytes; the 24-bit SPI address is truncated to these low bits, so accesses wrap modulo 2**MEM_ADDR_BITS.
- PAGE_BITS, 5: log2 of page size (32 bytes) for page mode.

Ports:
- clk  input  1  system clock, also the SPI bit clock: one bit per cycle, no separate sck.
- rst  input  1  synchronous active-high reset.
- cs_n  input  1  chip select, active low.
- mosi  input  1  serial data from master, MSB first.
- miso  output  1  serial data to master, registered, MSB first.
- ld_en  input  1  backdoor write strobe.
- ld_addr  input  MEM_ADDR_BITS  backdoor byte address.
- ld_data  input  8  backdoor write data.

Behaviour:
- **Timing:** all logic is on posedge clk. mosi is sampled at every edge where cs_n=0. miso is a flop.
- **Reset** (rst=1 at an edge):
  - state=CMD, bit counter=0, miso=0, mode=8'h40 (sequential).
  - Array contents are not reset.
  - rst overrides cs_n and ld_en.
- **cs_n=1 at an edge:** state=CMD, bit counter=0, miso=0. mosi is ignored; ld_en is still honoured. This applies mid-transfer: a partial write byte is discarded, and the address and data already written are kept.
- **States:** CMD, ADDR, RDATA, WDATA, RDMR, WRMR, IGNORE.
- **CMD:** shift 8 bits. At the edge sampling bit 0, decode:
  - 8'h03 READ -> ADDR
  - 8'h02 WRITE -> ADDR
  - 8'h05 RDMR -> RDMR, and miso<=mode[7] at that same edge
  - 8'h01 WRMR -> WRMR
  - anything else -> IGNORE
- **ADDR:** shift 24 bits, MSB first. At the edge sampling bit 0, addr<=truncated address, then:
  - READ -> RDATA, and miso<=mem[addr][7] at that same edge (array read is combinational or prefetched; zero dummy cycles).
  - WRITE -> WDATA.
- **RDATA:**
  - miso advances one bit per edge: bit6..bit0.
  - The edge after bit0 is driven loads the next byte's bit7 from the next address (see Address advance).
  - mosi is ignored.
- **WDATA:**
  - Shift 8 bits; at the edge sampling the 8th bit, write mem[addr] and advance the address.
  - Continues until cs_n=1.
- **RDMR:** miso repeats mode[7:0] continuously, MSB first.
- **WRMR:**
  - At the 8th data bit, mode<=shifted byte. Only mode[7:6] are stored; mode[5:0] always read as 0.
  - Further bits are ignored until cs_n=1.
- **IGNORE:** miso=0 until cs_n=1.
- **Address advance, by mode[7:6]:**
  - 2'b00 byte: address holds; repeated reads return the same byte, repeated writes overwrite the same byte.
  - 2'b10 page: low PAGE_BITS increment and wrap within the page.
  - 2'b01 sequential: full increment, wrapping at 2**MEM_ADDR_BITS-1 -> 0.
  - 2'b11: treated as sequential.
- **miso outside RDATA/RDMR:** 0.
- **Backdoor:** ld_en=1 writes mem[ld_addr]<=ld_data at that edge. If an SPI write targets the same address in the same cycle, the SPI write wins.
- **Latency, READ:** 32 edges after cs_n falls (8 command + 24 address), the first data MSB is on miso for the 33rd cycle. The master samples it on that following edge.
- **Width rules:** the bit counter is 5 bits (0..23). The address register is MEM_ADDR_BITS wide; upper address bits are dropped silently.

Test Plan:
- **Reset default:** rst, then RDMR (cs_n low, 8'h05) -> miso streams 8'h40 repeatedly; the byte following is also 8'h40.
- **Backdoor + sequential read:** preload 0x1234=8'hA5, 0x1235=8'h3C; send 8'h03, 24'h001234, clock 16 more bits -> miso bits 8'hA5 then 8'h3C. The MSB is valid in the cycle after the last address bit.
- **Write then read, wrap:** WRITE at 24'h00FFFF with bytes 8'h11, 8'h22, cs_n high; READ 24'h000000 -> 8'h22 (sequential wrap at MEM_ADDR_BITS=16). Also READ 24'h01FFFF -> 8'h11 (upper bits dropped).
- **Page mode:** WRMR 8'h80; WRITE at 24'h00001F bytes 8'hDE, 8'hAD -> mem[0x1F]=8'hDE, mem[0x00]=8'hAD, mem[0x20] unchanged.
- **Abort mid-byte:** WRITE at 24'h000010, send 5 bits of 8'hFF then cs_n=1 -> mem[0x10] unchanged, next command decodes correctly.
- **Illegal command and simultaneous writes:**
  - Command 8'h9F -> miso stays 0 through 16 further cycles.
  - Same-cycle SPI write and ld_en to one address -> SPI data retained.

Source files
------------

// File: rtl/spi_sram_slave.sv
// spi_sram_slave
//   SPI SRAM responder with a 23LC1024-style command set (READ 0x03,
//   WRITE 0x02, RDMR 0x05, WRMR 0x01). clk doubles as the SPI bit clock:
//   one bit moves in each direction on every rising edge while cs_n is low.
//   The backing array is not reset. A backdoor port preloads images.
//
// Ports
//   clk      system clock and SPI bit clock
//   rst      synchronous active-high reset (overrides cs_n and ld_en)
//   cs_n     chip select, active low
//   mosi     serial data in, MSB first
//   miso     serial data out, registered, MSB first
//   ld_en    backdoor write strobe
//   ld_addr  backdoor byte address
//   ld_data  backdoor write data
module spi_sram_slave #(
    parameter int MEM_ADDR_BITS = 16,
    parameter int PAGE_BITS     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs_n,
    input  logic                     mosi,
    output logic                     miso,
    input  logic                     ld_en,
    input  logic [MEM_ADDR_BITS-1:0] ld_addr,
    input  logic [7:0]               ld_data
);

    localparam int MEM_BYTES = 1 << MEM_ADDR_BITS;
    // Shift register only needs enough history to assemble the kept
    // address bits (or a command/data byte) together with the live mosi bit.
    localparam int SHIFT_W   = (MEM_ADDR_BITS - 1 > 7) ? (MEM_ADDR_BITS - 1) : 7;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;

    localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE = {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [PAGE_BITS-1:0]     PAGE_ONE = {{(PAGE_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_RDATA  = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RDMR   = 3'd4,
        ST_WRMR   = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // Address advance after each data byte, selected by mode[7:6].
    function automatic logic [MEM_ADDR_BITS-1:0] next_addr(
        input logic [MEM_ADDR_BITS-1:0] a,
        input logic [1:0]               m
    );
        logic [MEM_ADDR_BITS-1:0] r;
        case (m)
            2'b00:   r = a;
            2'b10:   r = {a[MEM_ADDR_BITS-1:PAGE_BITS], a[PAGE_BITS-1:0] + PAGE_ONE};
            default: r = a + ADDR_ONE;
        endcase
        return r;
    endfunction

    logic [7:0]               mem_r [0:MEM_BYTES-1];

    state_t                   state_r,   state_s;
    logic [4:0]               bit_cnt_r, bit_cnt_s;
    logic [SHIFT_W-1:0]       shift_r,   shift_s;
    logic                     is_read_r, is_read_s;
    logic [MEM_ADDR_BITS-1:0] addr_r,    addr_s;
    logic                     miso_r,    miso_s;
    logic [1:0]               mode_r,    mode_s;     // only mode[7:6] are stored

    logic                     mem_we_s;
    logic [7:0]               in_byte_s;
    logic [7:0]               mode_byte_s;
    logic [MEM_ADDR_BITS-1:0] new_addr_s;
    logic [MEM_ADDR_BITS-1:0] rd_addr_s;
    logic [7:0]               rd_byte_s;
    logic [2:0]               bit_idx_s;

    assign in_byte_s   = {shift_r[6:0], mosi};
    assign mode_byte_s = {mode_r, 6'b000000};
    assign new_addr_s  = {shift_r[MEM_ADDR_BITS-2:0], mosi};
    assign bit_idx_s   = 3'd7 - bit_cnt_r[2:0];
    assign rd_byte_s   = mem_r[rd_addr_s];
    assign miso        = miso_r;

    // Read-port address: the freshly assembled address on the last address
    // bit, the advanced address at a byte boundary in RDATA, else the current one.
    always_comb begin
        rd_addr_s = addr_r;
        if (state_r == ST_ADDR) begin
            rd_addr_s = new_addr_s;
        end else if ((state_r == ST_RDATA) && (bit_cnt_r[2:0] == 3'd0)) begin
            rd_addr_s = next_addr(addr_r, mode_r);
        end else begin
            rd_addr_s = addr_r;
        end
    end

    // Next-state and next-output logic for the SPI protocol engine.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = {shift_r[SHIFT_W-2:0], mosi};
        is_read_s = is_read_r;
        addr_s    = addr_r;
        miso_s    = 1'b0;
        mode_s    = mode_r;
        mem_we_s  = 1'b0;

        if (cs_n) begin
            state_s   = ST_CMD;
            bit_cnt_s = 5'd0;
        end else begin
            case (state_r)
                ST_CMD: begin
                    if (bit_cnt_r == 5'd7) begin
                        bit_cnt_s = 5'd0;
                        case (in_byte_s)
                            CMD_READ: begin
                                state_s   = ST_ADDR;
                                is_read_s = 1'b1;
                            end
                            CMD_WRITE: begin
                                state_s   = ST_ADDR;
                                is_read_s = 1'b0;
                            end
                            CMD_RDMR: begin
                                // MSB goes out on the decode edge; counter
                                // holds the index of the next bit to drive.
                                state_s   = ST_RDMR;
                                miso_s    = mode_byte_s[7];
                                bit_cnt_s = 5'd1;
                            end
                            CMD_WRMR: begin
                                state_s   = ST_WRMR;
                            end
                            default: begin
                                state_s   = ST_IGNORE;
                            end
                        endcase
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end

                ST_ADDR: begin
                    if (bit_cnt_r == 5'd23) begin
                        addr_s = new_addr_s;
                        if (is_read_r) begin
                            // Zero dummy cycles: first data MSB on this edge.
                            state_s   = ST_RDATA;
                            miso_s    = rd_byte_s[7];
                            bit_cnt_s = 5'd1;
                        end else begin
                            state_s   = ST_WDATA;
                            bit_cnt_s = 5'd0;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end

                ST_RDATA: begin
                    // Counter value 0 marks a byte boundary: rd_byte_s then
                    // already comes from the advanced address.
                    miso_s    = rd_byte_s[bit_idx_s];
                    bit_cnt_s = {2'b00, bit_cnt_r[2:0] + 3'd1};
                    if (bit_cnt_r[2:0] == 3'd0) begin
                        addr_s = rd_addr_s;
                    end else begin
                        addr_s = addr_r;
                    end
                end

                ST_WDATA: begin
                    if (bit_cnt_r == 5'd7) begin
                        mem_we_s  = 1'b1;
                        addr_s    = next_addr(addr_r, mode_r);
                        bit_cnt_s = 5'd0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end

                ST_RDMR: begin
                    miso_s    = mode_byte_s[bit_idx_s];
                    bit_cnt_s = {2'b00, bit_cnt_r[2:0] + 3'd1};
                end

                ST_WRMR: begin
                    if (bit_cnt_r == 5'd7) begin
                        // Later bits are discarded, which is exactly IGNORE.
                        mode_s    = in_byte_s[7:6];
                        state_s   = ST_IGNORE;
                        bit_cnt_s = 5'd0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end

                ST_IGNORE: begin
                    state_s = ST_IGNORE;
                end

                default: begin
                    state_s   = ST_CMD;
                    bit_cnt_s = 5'd0;
                end
            endcase
        end
    end

    // Protocol state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CMD;
            bit_cnt_r <= 5'd0;
            shift_r   <= {SHIFT_W{1'b0}};
            is_read_r <= 1'b0;
            addr_r    <= {MEM_ADDR_BITS{1'b0}};
            miso_r    <= 1'b0;
            mode_r    <= 2'b01;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            is_read_r <= is_read_s;
            addr_r    <= addr_s;
            miso_r    <= miso_s;
            mode_r    <= mode_s;
        end
    end

    // Backing array: backdoor write first so a same-address SPI write wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_en) begin
                mem_r[ld_addr] <= ld_data;
            end
            if (mem_we_s) begin
                mem_r[addr_r] <= in_byte_s;
            end
        end
    end

endmodule

// File: tb/tb_spi_sram_slave.sv
// Directed testbench for spi_sram_slave: command/address/data streams are
// shifted in bit by bit and miso is captured one time unit after each edge.
module tb_spi_sram_slave;

    logic        clk;
    logic        rst;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;

    int          checks;
    int          errors;
    logic [63:0] rx;

    spi_sram_slave #(
        .MEM_ADDR_BITS (16),
        .PAGE_BITS     (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift nbits of tx (right-aligned, MSB first) with cs_n low, capturing
    // miso after every edge; optional backdoor pulse on bit index ld_at.
    task automatic spi_xfer(input logic [63:0] tx, input int nbits, input int ld_at,
                            input logic [15:0] la, input logic [7:0] ldd,
                            output logic [63:0] rxo);
        rxo = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            cs_n = 1'b0;
            mosi = tx[nbits-1-i];
            if (i == ld_at) begin
                ld_en = 1'b1; ld_addr = la; ld_data = ldd;
            end else begin
                ld_en = 1'b0;
            end
            @(posedge clk); #1;
            rxo = {rxo[62:0], miso};
        end
        @(negedge clk);
        cs_n = 1'b1; mosi = 1'b0; ld_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic spi_simple(input logic [63:0] tx, input int nbits, output logic [63:0] rxo);
        spi_xfer(tx, nbits, -1, 16'h0, 8'h0, rxo);
    endtask

    // READ of nbytes: the last data bit is sampled on the edge after bit 0
    // would be needed, so one fewer clock than 32 + 8*nbytes.
    task automatic spi_read(input logic [23:0] a, input int nbytes, output logic [63:0] rxo);
        logic [63:0] tx;
        tx = {32'h0, 8'h03, a} << (8 * nbytes - 1);
        spi_simple(tx, 32 + 8 * nbytes - 1, rxo);
    endtask

    task automatic spi_rdmr(output logic [63:0] rxo);
        spi_simple(64'h5 << 15, 23, rxo);
    endtask

    task automatic spi_wrmr(input logic [7:0] m, output logic [63:0] rxo);
        spi_simple({40'h0, 8'h01, m, 8'h00}, 24, rxo);
    endtask

    task automatic ld_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        ld_en = 1'b0; ld_addr = 16'h0; ld_data = 8'h0;

        // Reset default
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_miso", {63'h0, miso}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        spi_rdmr(rx);
        check_eq("rdmr_reset", {48'h0, rx[15:0]}, 64'h4040);
        check_eq("rdmr_cmd_quiet", {57'h0, rx[22:16]}, 64'h0);

        // Backdoor preload + sequential read
        ld_write(16'h1234, 8'hA5);
        ld_write(16'h1235, 8'h3C);
        spi_read(24'h001234, 2, rx);
        check_eq("seq_read", {48'h0, rx[15:0]}, 64'hA53C);
        check_eq("read_pre_zero", {33'h0, rx[46:16]}, 64'h0);
        check_eq("idle_miso", {63'h0, miso}, 64'h0);

        // Write across the top of the array, then read back with wrap
        spi_simple({16'h0, 8'h02, 24'h00FFFF, 16'h1122}, 48, rx);
        check_eq("write_miso_quiet", rx, 64'h0);
        spi_read(24'h000000, 1, rx);
        check_eq("wrap_write", {56'h0, rx[7:0]}, 64'h22);
        spi_read(24'h01FFFF, 1, rx);
        check_eq("upper_addr_drop", {56'h0, rx[7:0]}, 64'h11);
        spi_read(24'h00FFFF, 2, rx);
        check_eq("wrap_read", {48'h0, rx[15:0]}, 64'h1122);

        // Page mode
        ld_write(16'h0020, 8'h5A);
        spi_wrmr(8'h80, rx);
        check_eq("wrmr_quiet", {40'h0, rx[23:0]}, 64'h0);
        spi_rdmr(rx);
        check_eq("rdmr_page", {48'h0, rx[15:0]}, 64'h8080);
        spi_simple({16'h0, 8'h02, 24'h00001F, 16'hDEAD}, 48, rx);
        spi_read(24'h00001F, 2, rx);
        check_eq("page_wrap", {48'h0, rx[15:0]}, 64'hDEAD);
        spi_read(24'h000020, 1, rx);
        check_eq("page_neighbor", {56'h0, rx[7:0]}, 64'h5A);

        // Byte mode, then mode 2'b11 behaves as sequential
        spi_wrmr(8'h3F, rx);
        spi_rdmr(rx);
        check_eq("rdmr_byte", {48'h0, rx[15:0]}, 64'h0000);
        spi_read(24'h00001F, 2, rx);
        check_eq("byte_mode_read", {48'h0, rx[15:0]}, 64'hDEDE);
        spi_wrmr(8'hC0, rx);
        spi_rdmr(rx);
        check_eq("rdmr_11", {48'h0, rx[15:0]}, 64'hC0C0);
        spi_read(24'h00001F, 2, rx);
        check_eq("mode11_seq", {48'h0, rx[15:0]}, 64'hDE5A);
        spi_wrmr(8'h40, rx);

        // Abort mid-byte
        ld_write(16'h0010, 8'h77);
        spi_simple({27'h0, 8'h02, 24'h000010, 5'b11111}, 37, rx);
        spi_read(24'h000010, 1, rx);
        check_eq("abort_keep", {56'h0, rx[7:0]}, 64'h77);

        // Illegal command
        spi_simple({40'h0, 8'h9F, 16'hFFFF}, 24, rx);
        check_eq("illegal_quiet", {40'h0, rx[23:0]}, 64'h0);
        spi_rdmr(rx);
        check_eq("after_illegal", {48'h0, rx[15:0]}, 64'h4040);

        // Same-cycle SPI write and backdoor write
        spi_xfer({24'h0, 8'h02, 24'h000040, 8'hC3}, 40, 39, 16'h0040, 8'h3C, rx);
        spi_read(24'h000040, 1, rx);
        check_eq("spi_wins", {56'h0, rx[7:0]}, 64'hC3);
        spi_xfer({24'h0, 8'h02, 24'h000060, 8'h81}, 40, 39, 16'h0061, 8'h42, rx);
        spi_read(24'h000060, 2, rx);
        check_eq("dual_write", {48'h0, rx[15:0]}, 64'h8142);

        // Reset overrides ld_en and restores the mode register
        ld_write(16'h0050, 8'h99);
        spi_wrmr(8'h80, rx);
        @(negedge clk);
        rst = 1'b1; cs_n = 1'b0; mosi = 1'b1;
        ld_en = 1'b1; ld_addr = 16'h0050; ld_data = 8'h00;
        @(posedge clk); #1;
        check_eq("rst_miso", {63'h0, miso}, 64'h0);
        @(negedge clk);
        rst = 1'b0; cs_n = 1'b1; mosi = 1'b0; ld_en = 1'b0;
        spi_rdmr(rx);
        check_eq("rdmr_after_rst", {48'h0, rx[15:0]}, 64'h4040);
        spi_read(24'h000050, 1, rx);
        check_eq("rst_blocks_ld", {56'h0, rx[7:0]}, 64'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
